// File: rtl/pe_array_pkg.sv
// Shared types and constants for the PE array controller.
// FLUSH_CYCLES covers skew drain, operand propagation and the PE pipeline.
package pe_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int FCW = 6;

    function automatic int FLUSH_CYCLES(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/pe_skew_shift.sv
// Operand-enable skew: tap r is the input delayed by r+1 cycles.
// Synchronous clear empties the pipe immediately.
module pe_skew_shift #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         shift_in,
    output logic [N-1:0] taps
);

    always_ff @(posedge clock) begin
        if (clear) begin
            taps <= '0;
        end else begin
            taps <= {taps[N-2:0], shift_in};
        end
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for an NxN systolic PE array: clear, feed K, flush, capture, done.
// Define PE_ARRAY_CTRL_PERF_EN to add the saturating o_busy_cycles counter.
module pe_array_ctrl
    import pe_array_pkg::*;
#(
    parameter int BW = 8,
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [AW-1:0] i_k_len,
    output logic          o_pe_clear,
    output logic [AW-1:0] o_rd_addr,
    output logic [N-1:0]  o_feed_en,
    output logic          o_capture,
    output logic          o_busy,
    output logic          o_done
`ifdef PE_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]   o_busy_cycles
`endif
);

    if (N < 2 || N > 16 || BW < 1) begin : g_bad_param
        $error("pe_array_ctrl: parameter out of range");
    end

    state_t         state;
    state_t         nxt;
    logic [AW-1:0]  k_len;
    logic [AW-1:0]  addr_n;
    logic [FCW-1:0] fcnt;
    logic [FCW-1:0] fcnt_n;
    logic           abort;
    logic           accept;
    logic           clear_n;
    logic           feed_n;
    logic           capture_n;
    logic           busy_n;
    logic           done_n;

    assign abort  = (state != S_IDLE) && i_abort;
    assign accept = (state == S_IDLE) && i_start && !i_abort;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
            k_len <= '0;
            fcnt  <= '0;
        end else begin
            state <= nxt;
            fcnt  <= fcnt_n;
            if (accept) begin
                k_len <= i_k_len;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (accept) nxt = S_CLEAR;
            S_CLEAR:   nxt = (k_len != '0) ? S_FEED : S_DONE;
            S_FEED:    if (o_rd_addr == k_len - AW'(1)) nxt = S_FLUSH;
            S_FLUSH: begin
                if (fcnt == FCW'(FLUSH_CYCLES(N) - 1)) nxt = S_CAPTURE;
            end
            S_CAPTURE: nxt = S_DONE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort) begin
            nxt = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        addr_n    = '0;
        fcnt_n    = '0;
        clear_n   = (nxt == S_CLEAR) || abort;
        feed_n    = (nxt == S_FEED);
        capture_n = (nxt == S_CAPTURE);
        busy_n    = (nxt != S_IDLE);
        done_n    = (nxt == S_DONE);
        if (state == S_FEED && nxt == S_FEED) begin
            addr_n = o_rd_addr + AW'(1);
        end
        if (state == S_FLUSH && nxt == S_FLUSH) begin
            fcnt_n = fcnt + FCW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_pe_clear <= 1'b1;
            o_rd_addr  <= '0;
            o_capture  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_pe_clear <= clear_n;
            o_rd_addr  <= addr_n;
            o_capture  <= capture_n;
            o_busy     <= busy_n;
            o_done     <= done_n;
        end
    end

    pe_skew_shift #(
        .N(N)
    ) u_skew (
        .clock    (i_clock),
        .clear    (i_reset || abort),
        .shift_in (feed_n),
        .taps     (o_feed_en)
    );

`ifdef PE_ARRAY_CTRL_PERF_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_busy_cycles <= '0;
        end else if (o_busy && o_busy_cycles != '1) begin
            o_busy_cycles <= o_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl (N=4, AW=8) against the job timeline.
// Covers PE_ARRAY_CTRL_PERF_EN when that macro is defined.
module tb_pe_array_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] k_len;
    logic       pe_clear;
    logic [7:0] rd_addr;
    logic [3:0] feed_en;
    logic       capture;
    logic       busy;
    logic       done;
`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] busy_cycles;
`endif

    int checks = 0;
    int errors = 0;

    pe_array_ctrl #(
        .BW(8),
        .N (4),
        .AW(8)
    ) dut (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_start   (start),
        .i_abort   (abort),
        .i_k_len   (k_len),
        .o_pe_clear(pe_clear),
        .o_rd_addr (rd_addr),
        .o_feed_en (feed_en),
        .o_capture (capture),
        .o_busy    (busy),
        .o_done    (done)
`ifdef PE_ARRAY_CTRL_PERF_EN
        ,
        .o_busy_cycles(busy_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input int cyc, input logic e_clr, input int e_addr,
                           input logic [3:0] e_feed, input logic e_cap,
                           input logic e_busy, input logic e_done);
        chk("pe_clear", cyc, 32'(pe_clear), 32'(e_clr));
        chk("rd_addr", cyc, 32'(rd_addr), 32'(e_addr));
        chk("feed_en", cyc, 32'(feed_en), 32'(e_feed));
        chk("capture", cyc, 32'(capture), 32'(e_cap));
        chk("busy", cyc, 32'(busy), 32'(e_busy));
        chk("done", cyc, 32'(done), 32'(e_done));
    endtask

    // Start at cycle 0 with K=k; optional second start, abort or reset cycle (-1 = none).
    task automatic job(input int k, input int st2, input int ab,
                       input int rs, input int ncyc);
        int cut;
        int cap;
        int dn;
        logic [3:0] ef;
        cut = 1 << 30;
        if (ab >= 0) cut = ab;
        if (rs >= 0 && rs < cut) cut = rs;
        cap = (k > 0) ? k + 10 : -1;
        dn  = (k > 0) ? k + 11 : 2;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == st2);
            k_len = (c == 0) ? 8'(k) : 8'd5;
            abort = (c == ab);
            reset = (c == rs);
            tick();
            begin
                int e;
                e = c + 1;
                if (e == cut + 1) begin
                    chk_all(e, 1'b1, 0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef PE_ARRAY_CTRL_PERF_EN
                    if (e == rs + 1) chk("busy_cycles", e, busy_cycles, 32'd0);
`endif
                end else if (e > cut + 1) begin
                    chk_all(e, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
                end else begin
                    ef = 4'h0;
                    for (int r = 0; r < 4; r++) begin
                        ef[r] = (k > 0) && (e >= 2 + r) && (e <= k + 1 + r);
                    end
                    chk_all(e, e == 1,
                            (e >= 2 && e <= k + 1) ? e - 2 : 0, ef,
                            e == cap, e >= 1 && e <= dn, e == dn);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = 8'd0;
        tick();
        chk_all(0, 1'b1, 0, 4'h0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        k_len = 8'd7;
        tick();
        chk_all(0, 1'b1, 0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk_all(0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // K=3 with a second start at cycle 6 that must be ignored
        job(3, 6, -1, -1, 17);
`ifdef PE_ARRAY_CTRL_PERF_EN
        chk("busy_cycles_total", 17, busy_cycles, 32'd14);
`endif

        // K=0 skips feed/flush/capture
        job(0, -1, -1, -1, 5);

        // abort during FEED
        job(3, -1, 3, -1, 8);

        // abort in DONE keeps that cycle's done pulse
        job(3, -1, 14, -1, 17);

        // reset during FLUSH
        job(3, -1, -1, 8, 12);

        // maximum K, no address wrap
        job(255, -1, -1, -1, 268);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        k_len = 8'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_all(1, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all(2, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
